// File: rtl/alu_cmd_master_if.sv
// Signal bundle between alu_cmd_master, its request producer, the shared ALU bus and the response consumer.
// The master modport is the alu_cmd_master view; slave is the environment view.
interface alu_cmd_master_if;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_cmd;
   logic [3:0] req_a;
   logic [3:0] req_b;

   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_cmd;
   logic       alu_oe;
   logic [7:0] alu_out;

   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] rsp_cmd;
   logic       rsp_err;

   modport master (
      input  req_valid, req_cmd, req_a, req_b, alu_out, rsp_ready,
      output req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_cmd, rsp_err
   );

   modport slave (
      output req_valid, req_cmd, req_a, req_b, alu_out, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_cmd, alu_oe, rsp_valid, rsp_data, rsp_cmd, rsp_err
   );
endinterface

// File: rtl/alu_cmd_master.sv
// Queues ALU requests, drives one at a time onto the ALU bus for SETTLE cycles, returns the captured result.
// Latency SETTLE+2 cycles from accept to rsp_valid (2 for divide-by-zero); req_ready drops when the FIFO is full.
module alu_cmd_master #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   alu_cmd_master_if.master        bus,
   output logic [15:0]             op_count
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [3:0] CMD_DIV = 4'b0110;

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] a;
      logic [3:0] b;
   } req_t;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   req_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   req_t          head;
   logic          div_zero;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] settle_cnt;
   logic          last_drive;
   logic          alu_oe;
   logic          rsp_valid;

   logic [3:0]    alu_a_q;
   logic [3:0]    alu_b_q;
   logic [3:0]    alu_cmd_q;
   logic [7:0]    rsp_data_q;
   logic [3:0]    rsp_cmd_q;
   logic          rsp_err_q;
   logic [15:0]   op_count_q;

   assign bus.req_ready = rst_n && !fifo_full;
   assign push          = bus.req_valid && bus.req_ready;
   assign head          = mem[rd_ptr];
   assign div_zero      = (head.cmd == CMD_DIV) && (head.b == 4'd0);
   assign last_drive    = (settle_cnt == CW'(SETTLE - 1));

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      alu_oe    = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = div_zero ? RESP : DRIVE;
            end
         end
         DRIVE: begin
            alu_oe = 1'b1;
            if (last_drive) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_full  <= 1'b0;
         fifo_empty <= 1'b1;
         settle_cnt <= '0;
         alu_a_q    <= 4'd0;
         alu_b_q    <= 4'd0;
         alu_cmd_q  <= 4'd0;
         rsp_data_q <= 8'd0;
         rsp_cmd_q  <= 4'd0;
         rsp_err_q  <= 1'b0;
         op_count_q <= 16'd0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leaves the occupancy, and so both flags, unchanged.
         if (push && !pop) begin
            fifo_empty <= 1'b0;
            fifo_full  <= ((wr_ptr + AW'(1)) == rd_ptr);
         end else if (pop && !push) begin
            fifo_full  <= 1'b0;
            fifo_empty <= ((rd_ptr + AW'(1)) == wr_ptr);
         end

         if (pop) begin
            rsp_cmd_q  <= head.cmd;
            settle_cnt <= '0;
            if (div_zero) begin
               rsp_data_q <= 8'hFF;
               rsp_err_q  <= 1'b1;
            end else begin
               // The ALU bus registers only change for operations that actually drive it.
               alu_a_q   <= head.a;
               alu_b_q   <= head.b;
               alu_cmd_q <= head.cmd;
            end
         end

         if (state == DRIVE) begin
            settle_cnt <= settle_cnt + CW'(1);
            if (last_drive) begin
               rsp_data_q <= bus.alu_out;
               rsp_err_q  <= 1'b0;
            end
         end

         if (rsp_valid && bus.rsp_ready) op_count_q <= op_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.req_cmd, bus.req_a, bus.req_b};
   end

   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_cmd   = alu_cmd_q;
   assign bus.alu_oe    = alu_oe;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_cmd   = rsp_cmd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with a behavioural ALU on the shared bus.
module tb_alu_cmd_master;
   localparam int         DEPTH  = 4;
   localparam int         SETTLE = 2;
   localparam logic [3:0] ADD  = 4'b0000;
   localparam logic [3:0] SUB  = 4'b0001;
   localparam logic [3:0] INC  = 4'b0011;
   localparam logic [3:0] MUL  = 4'b0101;
   localparam logic [3:0] DIV  = 4'b0110;
   localparam logic [3:0] BUFF = 4'b1111;

   typedef struct {
      logic [3:0] cmd;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] data;
      logic       err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] op_count;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count;
   logic [3:0]  last_a, last_b, last_cmd;
   logic [7:0]  alu_res;
   vec_t        vecs [12];

   alu_cmd_master_if bus();

   alu_cmd_master #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   // Reference ALU; drives a marker value when not enabled so a misplaced capture is visible.
   always_comb begin
      alu_res = 8'hEE;
      if (bus.alu_oe) begin
         case (bus.alu_cmd)
            ADD:     alu_res = 8'(bus.alu_a) + 8'(bus.alu_b);
            SUB:     alu_res = 8'(bus.alu_a) - 8'(bus.alu_b);
            INC:     alu_res = 8'(bus.alu_a) + 8'd1;
            MUL:     alu_res = 8'(bus.alu_a) * 8'(bus.alu_b);
            DIV:     alu_res = (bus.alu_b != 4'd0) ? 8'(bus.alu_a / bus.alu_b) : 8'hFF;
            BUFF:    alu_res = 8'(bus.alu_a);
            default: alu_res = 8'h00;
         endcase
      end
      bus.alu_out = alu_res;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      exp_count = 16'd0;
      last_a    = 4'd0;
      last_b    = 4'd0;
      last_cmd  = 4'd0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat, oe_n, oe_first;
      lat = 0; oe_n = 0; oe_first = 0;
      @(negedge clk);
      bus.req_cmd   = v.cmd;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      chk($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (bus.alu_oe) begin
            oe_n++;
            if (oe_first == 0) oe_first = c;
            chk($sformatf("v%0d_alu_a", idx), 32'(bus.alu_a), 32'(v.a));
            chk($sformatf("v%0d_alu_b", idx), 32'(bus.alu_b), 32'(v.b));
            chk($sformatf("v%0d_alu_cmd", idx), 32'(bus.alu_cmd), 32'(v.cmd));
         end
         if (bus.rsp_valid) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_latency", idx), 32'(lat), v.err ? 32'd2 : 32'(SETTLE + 2));
      chk($sformatf("v%0d_oe_cycles", idx), 32'(oe_n), v.err ? 32'd0 : 32'(SETTLE));
      chk($sformatf("v%0d_oe_first", idx), 32'(oe_first), v.err ? 32'd0 : 32'd2);
      chk($sformatf("v%0d_rsp_data", idx), 32'(bus.rsp_data), 32'(v.data));
      chk($sformatf("v%0d_rsp_err", idx), 32'(bus.rsp_err), 32'(v.err));
      chk($sformatf("v%0d_rsp_cmd", idx), 32'(bus.rsp_cmd), 32'(v.cmd));
      if (!v.err) begin
         last_a   = v.a;
         last_b   = v.b;
         last_cmd = v.cmd;
      end
      exp_count = exp_count + 16'd1;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid_drop", idx), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_op_count", idx), 32'(op_count), 32'(exp_count));
      chk($sformatf("v%0d_alu_oe_idle", idx), 32'(bus.alu_oe), 32'd0);
      chk($sformatf("v%0d_hold_a", idx), 32'(bus.alu_a), 32'(last_a));
      chk($sformatf("v%0d_hold_b", idx), 32'(bus.alu_b), 32'(last_b));
      chk($sformatf("v%0d_hold_cmd", idx), 32'(bus.alu_cmd), 32'(last_cmd));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   bad, n, rises, accepted, waited;
      int   r1, r2, rise2;
      logic [7:0] d1, d2;
      logic [3:0] c1, c2;
      logic prev_oe;
      vec_t w;

      vecs[0]  = '{ADD,  4'hD, 4'h9, 8'h16, 1'b0};
      vecs[1]  = '{SUB,  4'h9, 4'h3, 8'h06, 1'b0};
      vecs[2]  = '{MUL,  4'hD, 4'h9, 8'h75, 1'b0};
      vecs[3]  = '{DIV,  4'hD, 4'h9, 8'h01, 1'b0};
      vecs[4]  = '{DIV,  4'h5, 4'h0, 8'hFF, 1'b1};
      vecs[5]  = '{INC,  4'h7, 4'h0, 8'h08, 1'b0};
      vecs[6]  = '{BUFF, 4'hA, 4'h2, 8'h0A, 1'b0};
      vecs[7]  = '{ADD,  4'hF, 4'hF, 8'h1E, 1'b0};
      vecs[8]  = '{MUL,  4'hF, 4'hF, 8'hE1, 1'b0};
      vecs[9]  = '{DIV,  4'hF, 4'h0, 8'hFF, 1'b1};
      vecs[10] = '{SUB,  4'h2, 4'h5, 8'hFD, 1'b0};
      vecs[11] = '{DIV,  4'hC, 4'h3, 8'h04, 1'b0};

      // Reset with a request presented throughout.
      rst_n         = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_cmd   = ADD;
      bus.req_a     = 4'h1;
      bus.req_b     = 4'h1;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_alu_oe", 32'(bus.alu_oe), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_rsp_cmd", 32'(bus.rsp_cmd), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
      chk("rst_alu_cmd", 32'(bus.alu_cmd), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      rst_n         = 1'b1;
      bus.req_valid = 1'b0;
      exp_count = 16'd0; last_a = 4'd0; last_b = 4'd0; last_cmd = 4'd0;
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      bad = 0;
      repeat (6) begin
         if (bus.rsp_valid || bus.alu_oe) bad++;
         @(negedge clk);
      end
      chk("rst_no_accept", 32'(bad), 32'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Back-to-back MUL then DIV.
      do_reset();
      @(negedge clk);
      bus.req_cmd = MUL; bus.req_a = 4'hD; bus.req_b = 4'h9;
      bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
      bus.req_cmd = DIV;
      n = 0; rises = 0; rise2 = 0; r1 = 0; r2 = 0; prev_oe = 1'b0;
      d1 = 8'h00; d2 = 8'h00; c1 = 4'h0; c2 = 4'h0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) bus.req_valid = 1'b0;
         if (bus.alu_oe && !prev_oe) begin
            rises++;
            if (rises == 2) rise2 = c;
         end
         prev_oe = bus.alu_oe;
         if (bus.rsp_valid) begin
            if (n == 0) begin r1 = c; d1 = bus.rsp_data; c1 = bus.rsp_cmd; end
            else if (n == 1) begin r2 = c; d2 = bus.rsp_data; c2 = bus.rsp_cmd; end
            n++;
         end
         @(negedge clk);
      end
      chk("b2b_rsp_count", 32'(n), 32'd2);
      chk("b2b_first_cycle", 32'(r1), 32'd4);
      chk("b2b_first_data", 32'(d1), 32'h75);
      chk("b2b_first_cmd", 32'(c1), 32'(MUL));
      chk("b2b_second_cycle", 32'(r2), 32'd8);
      chk("b2b_second_data", 32'(d2), 32'h01);
      chk("b2b_second_cmd", 32'(c2), 32'(DIV));
      chk("b2b_second_oe_rise", 32'(rise2), 32'd6);
      chk("b2b_op_count", 32'(op_count), 32'd2);

      // Backpressure: consumer stalled, INC a=0..5 offered in turn.
      do_reset();
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.req_cmd = INC; bus.req_a = 4'(i); bus.req_b = 4'h0; bus.req_valid = 1'b1;
         waited = 0;
         while (!bus.req_ready && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         if (bus.req_ready) accepted++;
         else break;
      end
      bus.req_valid = 1'b0;
      chk("bp_accepted", 32'(accepted), 32'd5);
      chk("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data_first", 32'(bus.rsp_data), 32'h01);
      repeat (3) @(negedge clk);
      chk("bp_rsp_valid_stable", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data_stable", 32'(bus.rsp_data), 32'h01);
      chk("bp_rsp_cmd_stable", 32'(bus.rsp_cmd), 32'(INC));
      bus.rsp_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         if (bus.rsp_valid) begin
            chk($sformatf("bp_order_%0d", n), 32'(bus.rsp_data), 32'(n + 1));
            n++;
         end
         @(negedge clk);
      end
      chk("bp_rsp_count", 32'(n), 32'd5);
      bad = 0;
      repeat (8) begin
         if (bus.rsp_valid) bad++;
         @(negedge clk);
      end
      chk("bp_no_extra_rsp", 32'(bad), 32'd0);
      chk("bp_op_count", 32'(op_count), 32'd5);

      // Reset while the first of three requests is on the ALU bus.
      do_reset();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.req_cmd = ADD; bus.req_a = 4'(i + 1); bus.req_b = 4'h1; bus.req_valid = 1'b1;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid_rst_in_drive", 32'(bus.alu_oe), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_alu_oe", 32'(bus.alu_oe), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_op_count", 32'(op_count), 32'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         if (bus.rsp_valid || bus.alu_oe) bad++;
         @(negedge clk);
      end
      chk("mid_rst_no_activity", 32'(bad), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);

      // op_count wrap from a preloaded near-terminal value.
      do_reset();
      @(negedge clk);
      force dut.op_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.op_count_q;
      @(negedge clk);
      chk("wrap_preload", 32'(op_count), 32'hFFFE);
      exp_count = 16'hFFFE;
      w = '{BUFF, 4'h3, 4'h0, 8'h03, 1'b0};
      run_vec(w, 20);
      w = '{BUFF, 4'hC, 4'h5, 8'h0C, 1'b0};
      run_vec(w, 21);
      chk("wrap_zero", 32'(op_count), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth in entries (power of two, >=2).
REQ-002 Parameter SETTLE, default 2, cycles alu_a/alu_b/alu_cmd are held with alu_oe=1 before capture (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request FIFO can accept.
REQ-007 req_cmd  input  4  ALU opcode (0000 ADD ... 0110 DIV ... 1111 BUFF).
REQ-008 req_a, req_b  input  4 each  operands.
REQ-009 alu_a, alu_b  output  4 each  operands to ALU.
REQ-010 alu_cmd  output  4  opcode to ALU.
REQ-011 alu_oe  output  1  ALU output enable.
REQ-012 alu_out  input  8  ALU result bus (high-Z when alu_oe=0).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  8  captured result.
REQ-016 rsp_cmd  output  4  opcode of the response.
REQ-017 rsp_err  output  1  request rejected (divide by zero).
REQ-018 op_count  output  16  completed responses.

Function
REQ-019 Request handshake: entry pushed when req_valid && req_ready at rising edge; req_ready = FIFO not full; push blocked when full even if a pop occurs the same cycle.
REQ-020 FIFO: DEPTH entries of {cmd,a,b}, first-in first-out, wrap-around read/write pointers, separate full/empty flags; no overwrite, no underflow.
REQ-021 FSM states IDLE, DRIVE, RESP; single outstanding operation.
REQ-022 IDLE: if FIFO non-empty, pop head into operand registers; if cmd=DIV and b=0 -> RESP with rsp_err=1, rsp_data=8'hFF; else -> DRIVE, settle counter cleared.
REQ-023 DRIVE: alu_oe=1, alu_a/alu_b/alu_cmd = registered operands, stable for exactly SETTLE cycles; on the last DRIVE cycle's edge alu_out captured into rsp_data, rsp_err=0, -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_data/rsp_cmd/rsp_err held stable until rsp_valid && rsp_ready; then -> IDLE, op_count+1 (wraps FFFF->0000).
REQ-025 alu_oe=0 in IDLE and RESP; alu_a/alu_b/alu_cmd hold last driven values when alu_oe=0.
REQ-026 Latency, FIFO empty and IDLE, request accepted cycle 0: rsp_valid rises cycle SETTLE+2 (4 at default); divide-by-zero: cycle 2.
REQ-027 Back-to-back: response handshake in RESP on cycle N with FIFO non-empty -> next pop at N+1, alu_oe=1 at N+2.
REQ-028 FIFO push continues during DRIVE/RESP; with rsp_ready held low, DEPTH+1 requests accepted (one in flight) before req_ready=0.
REQ-029 Result width: rsp_data is alu_out verbatim, 8 bits, no sign handling.

Reset
REQ-030 rst_n=0 at an edge: state IDLE, FIFO empty, req_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_cmd=0, rsp_err=0, alu_oe=0, alu_a=alu_b=alu_cmd=0, op_count=0, settle counter 0.
REQ-031 Reset mid-operation (any state) discards in-flight and queued requests; no response emitted for them.
REQ-032 Requests presented while rst_n=0 are not accepted.

Verification
REQ-033 ADD a=1101 b=1001, rsp_ready=1 -> rsp_data=8'h16, rsp_err=0, rsp_valid at cycle 4, alu_oe high cycles 2-3 only.
REQ-034 MUL a=1101 b=1001 then DIV a=1101 b=1001 back-to-back -> rsp_data 8'h75 then 8'h01, in order, op_count=2.
REQ-035 DIV a=0101 b=0000 -> rsp_err=1, rsp_data=8'hFF, alu_oe never asserted, rsp_valid at cycle 2.
REQ-036 rsp_ready=0, push INC a=0..5 continuously -> 5 accepted, req_ready=0; release rsp_ready -> rsp_data 01,02,03,04,05 in order.
REQ-037 rst_n low during DRIVE with 2 queued -> next cycle alu_oe=0, rsp_valid=0, op_count=0, no further responses.
REQ-038 Preload op_count path by 65536 completed BUFF ops -> op_count wraps to 0000.
